// File: rtl/fwd_dest_pipe.sv
// fwd_dest_pipe: EX/MEM and MEM/WB destination pipeline on the producer side of operand forwarding.
// It carries the destination register, write-enable and opcode of each instruction from EX into
// MEM and then WB. It drives the forwarding-side view (mem_reg/wb_mem/wb_reg/wb_wb/mem_opcode),
// the register-file write port and a per-register pending-write scoreboard.
// Optional feature: define FWD_PIPE_STATS_EN to add saturating stall/flush event counters.
module fwd_dest_pipe #(
  parameter int unsigned REG_W   = 3,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned LOAD_OP = 10,
  parameter int unsigned NOP_OP  = 0
`ifdef FWD_PIPE_STATS_EN
  ,
  parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic [OP_W-1:0]         ex_opcode,
  input  logic [REG_W-1:0]        ex_dest,
  input  logic                    ex_wb,
  input  logic                    stall,
  input  logic                    flush,
  output logic [OP_W-1:0]         mem_opcode,
  output logic [REG_W-1:0]        mem_reg,
  output logic                    wb_mem,
  output logic [REG_W-1:0]        wb_reg,
  output logic                    wb_wb,
  output logic                    rf_we,
  output logic [REG_W-1:0]        rf_waddr,
  output logic [(1<<REG_W)-1:0]   busy,
  output logic                    load_in_mem
`ifdef FWD_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
`endif
);

  localparam int unsigned NumRegs = 1 << REG_W;
  localparam logic [OP_W-1:0] LoadOp = OP_W'(LOAD_OP);
  localparam logic [OP_W-1:0] NopOp  = OP_W'(NOP_OP);

  logic                q_wb;
  logic                mem_load;
  logic [OP_W-1:0]     mem_opcode_d;
  logic [REG_W-1:0]    mem_reg_d;
  logic                wb_mem_d;

  // Writes to r0 are architecturally dead, so they never become pending writes.
  assign q_wb     = ex_valid & ex_wb & (ex_dest != '0);
  // A bubble enters MEM on flush, stall (EX is held upstream) or an empty EX slot.
  assign mem_load = ex_valid & ~stall & ~flush;

  // MEM stage next state: either the EX instruction or a bubble.
  always_comb begin
    mem_opcode_d = NopOp;
    mem_reg_d    = '0;
    wb_mem_d     = 1'b0;
    if (mem_load) begin
      mem_opcode_d = ex_opcode;
      mem_reg_d    = ex_dest;
      wb_mem_d     = q_wb;
    end
  end

  // Pipeline registers; WB advances unconditionally so a stalled load still drains to WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_opcode <= NopOp;
      mem_reg    <= '0;
      wb_mem     <= 1'b0;
      wb_reg     <= '0;
      wb_wb      <= 1'b0;
    end else begin
      mem_opcode <= mem_opcode_d;
      mem_reg    <= mem_reg_d;
      wb_mem     <= wb_mem_d;
      wb_reg     <= mem_reg;
      wb_wb      <= wb_mem;
    end
  end

  assign rf_we       = wb_wb;
  assign rf_waddr    = wb_reg;
  assign load_in_mem = (mem_opcode == LoadOp);

  // Pending-write scoreboard over MEM and WB; r0 is never marked busy.
  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NumRegs; r++) begin
      if ((wb_mem && (mem_reg == REG_W'(r))) || (wb_wb && (wb_reg == REG_W'(r)))) begin
        busy[r] = 1'b1;
      end
    end
  end

`ifdef FWD_PIPE_STATS_EN
  // Saturating event counters; a flush during a stall counts only as a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (stall && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
